// File: rtl/pulse_dac_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_dac_gen
// Brief    : Complementary two-channel pulse DAC driver (follow / free-run /
//            counted burst) with programmable dead-time at every phase change.
// Revision : 1.0  initial release
// ============================================================================

module pulse_dac_gen #(
  parameter int DAC_WIDTH   = 14,
  parameter int CNT_WIDTH   = 24,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [1:0]             i_mode,
  input  logic                   i_p_in,
  input  logic                   i_start,
  input  logic [DAC_WIDTH-1:0]   i_level_hi,
  input  logic [DAC_WIDTH-1:0]   i_level_lo,
  input  logic [CNT_WIDTH-1:0]   i_half_period,
  input  logic [CNT_WIDTH-1:0]   i_dead_time,
  input  logic [BURST_WIDTH-1:0] i_burst_count,
  output logic [DAC_WIDTH-1:0]   o_dac_a,
  output logic [DAC_WIDTH-1:0]   o_dac_b,
  output logic                   o_phase,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam logic [1:0]             c_MODE_FOLLOW = 2'd0;
  localparam logic [1:0]             c_MODE_FREE   = 2'd1;
  localparam logic [1:0]             c_MODE_BURST  = 2'd2;
  localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] c_BURST_ONE   = BURST_WIDTH'(1);

  state_t                 r_state, w_state;
  logic                   r_phase, w_phase;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt;
  logic [BURST_WIDTH-1:0] r_remaining, w_remaining;
  logic                   r_done, w_done;
  logic                   w_latch;
  logic                   r_busy;
  logic                   r_pin;
  logic [1:0]             r_mode;
  logic [CNT_WIDTH-1:0]   r_half, r_dead;
  logic [DAC_WIDTH-1:0]   r_dac_a, r_dac_b, w_dac_a, w_dac_b;
  logic [CNT_WIDTH-1:0]   w_in_half_m1, w_half_m1;

  // A half-period of 0 behaves as 1, so the reload value floors at 0.
  assign w_in_half_m1 = (i_half_period == '0) ? '0 : i_half_period - c_CNT_ONE;
  assign w_half_m1    = (r_half == '0) ? '0 : r_half - c_CNT_ONE;

  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_cnt       = r_cnt;
    w_remaining = r_remaining;
    w_done      = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase     = 1'b0;
        w_cnt       = '0;
        w_remaining = '0;
        if (i_enable) begin
          case (i_mode)
            c_MODE_FOLLOW: begin
              w_state = S_HOLD;
              w_latch = 1'b1;
            end
            c_MODE_FREE: begin
              w_state = S_HOLD;
              w_phase = 1'b1;
              w_cnt   = w_in_half_m1;
              w_latch = 1'b1;
            end
            c_MODE_BURST: begin
              if (i_start) begin
                if (i_burst_count == '0) begin
                  w_done = 1'b1;
                end else begin
                  w_state     = S_HOLD;
                  w_phase     = 1'b1;
                  w_cnt       = w_in_half_m1;
                  w_remaining = i_burst_count;
                  w_latch     = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_HOLD: begin
        if (r_mode == c_MODE_FOLLOW) begin
          if (r_pin != r_phase) begin
            if (r_dead == '0) begin
              w_phase = r_pin;
            end else begin
              w_state = S_DEAD;
              w_cnt   = r_dead - c_CNT_ONE;
            end
          end
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - c_CNT_ONE;
        end else if (r_mode == c_MODE_BURST && !r_phase && r_remaining == c_BURST_ONE) begin
          // Last low half of a burst: no trailing dead-time.
          w_state     = S_IDLE;
          w_phase     = 1'b0;
          w_remaining = '0;
          w_done      = 1'b1;
        end else begin
          if (r_mode == c_MODE_BURST && !r_phase) begin
            w_remaining = r_remaining - c_BURST_ONE;
          end
          if (r_dead == '0) begin
            w_phase = ~r_phase;
            w_cnt   = w_half_m1;
          end else begin
            w_state = S_DEAD;
            w_cnt   = r_dead - c_CNT_ONE;
          end
        end
      end
      S_DEAD: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - c_CNT_ONE;
        end else begin
          w_state = S_HOLD;
          if (r_mode == c_MODE_FOLLOW) begin
            w_phase = r_pin;
            w_cnt   = '0;
          end else begin
            w_phase = ~r_phase;
            w_cnt   = w_half_m1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_phase = 1'b0;
        w_cnt   = '0;
      end
    endcase
    if (!i_enable) begin
      w_state     = S_IDLE;
      w_phase     = 1'b0;
      w_cnt       = '0;
      w_remaining = '0;
      w_done      = 1'b0;
      w_latch     = 1'b0;
    end
  end

  always_comb begin
    w_dac_a = i_level_lo;
    w_dac_b = i_level_hi;
    if (w_state == S_DEAD) begin
      w_dac_b = i_level_lo;
    end else if (w_phase) begin
      w_dac_a = i_level_hi;
      w_dac_b = i_level_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_cnt       <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_pin       <= 1'b0;
      r_mode      <= '0;
      r_half      <= '0;
      r_dead      <= '0;
      r_dac_a     <= '0;
      r_dac_b     <= '0;
    end else begin
      r_state     <= w_state;
      r_phase     <= w_phase;
      r_cnt       <= w_cnt;
      r_remaining <= w_remaining;
      r_done      <= w_done;
      r_busy      <= (w_state != S_IDLE);
      r_pin       <= i_p_in;
      r_dac_a     <= w_dac_a;
      r_dac_b     <= w_dac_b;
      if (w_latch) begin
        r_mode <= i_mode;
        r_half <= i_half_period;
        r_dead <= i_dead_time;
      end
    end
  end

  assign o_dac_a = r_dac_a;
  assign o_dac_b = r_dac_b;
  assign o_phase = r_phase;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

`default_nettype wire

// File: doc/pulse_dac_gen.md
Name: pulse_dac_gen

Overview:
Parametrised, clocked successor to the static two-level pulse DAC driver. Drives two complementary DAC channels between programmable high/low codes. Three modes: follow an external pulse, free-run a square wave, or emit a counted burst. Programmable dead-time is inserted at every phase change. Sits between the SPGD perturbation sequencer and the two DAC output registers.

Parameters:
DAC_WIDTH, 14, width of DAC codes (offset binary, unsigned)
CNT_WIDTH, 24, width of half-period and dead-time counters
BURST_WIDTH, 16, width of burst-count register

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
enable  in  1  block enable; low forces IDLE next cycle
mode  in  2  0=follow p_in, 1=free-run, 2=burst, 3=reserved (stay IDLE)
p_in  in  1  external pulse, used in mode 0
start  in  1  single-cycle burst trigger, used in mode 2
level_hi  in  DAC_WIDTH  high code
level_lo  in  DAC_WIDTH  low/idle code
half_period  in  CNT_WIDTH  cycles per half-period (modes 1, 2); 0 treated as 1
dead_time  in  CNT_WIDTH  cycles both channels held at level_lo per phase change; 0 = none
burst_count  in  BURST_WIDTH  full periods per burst (mode 2)
dac_a  out  DAC_WIDTH  channel A code, registered
dac_b  out  DAC_WIDTH  channel B code, registered
phase  out  1  current phase; 1 = A high
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset: dac_a=0, dac_b=0, phase=0, busy=0, done=0, state=IDLE, all counters 0.
- Output mapping (registered, no combinational path from inputs):
  - phase=1 -> dac_a=level_hi, dac_b=level_lo.
  - phase=0 -> dac_a=level_lo, dac_b=level_hi.
  - DEAD state -> dac_a=dac_b=level_lo.
- level_hi/level_lo are used live; a change appears on the outputs 1 cycle later.
- States: IDLE, HOLD, DEAD.
- IDLE: phase=0 mapping. Mode, half_period, dead_time and burst_count are latched when IDLE is left and are ignored until the block returns to IDLE.
  - enable=1, mode=0 -> HOLD.
  - enable=1, mode=1 -> HOLD with phase=1.
  - enable=1, mode=2, start=1 -> HOLD with phase=1, remaining=burst_count.
  - mode=2 with burst_count=0 -> stay IDLE, done=1 for 1 cycle.
- Mode 0 (HOLD):
  - p_in is registered once.
  - When registered p_in != phase: dead_time=0 -> phase updates, outputs follow 1 cycle after registered p_in changes (2 cycles after p_in).
  - dead_time>0 -> DEAD for dead_time cycles, then HOLD with phase = registered p_in value at DEAD exit.
  - Pulses shorter than dead_time are resolved only by the value at DEAD exit.
- Modes 1/2 (HOLD):
  - Phase held exactly max(half_period,1) cycles, then DEAD for dead_time cycles (skipped if 0), then HOLD with inverted phase.
  - Full period = 2*(half_period + dead_time).
- Mode 2 completion: remaining decrements at the end of each phase-0 HOLD. On reaching 0, go to IDLE with no trailing dead-time and pulse done=1 on the same cycle IDLE is entered.
- start while busy is ignored; start in mode 0 or 1 is ignored.
- enable=0 in any state: next cycle IDLE, phase=0, counters cleared, done not asserted. A burst is aborted without done.
- rst mid-operation overrides everything and produces the reset values next cycle.
- Counters saturate-free: a load of N counts exactly N cycles (counter loaded with N-1, transition on 0).

Test Plan:
1. Reset, then idle with enable=0, level_hi=0x2000, level_lo=0x0000 -> dac_a=0x0000, dac_b=0x2000, busy=0.
2. Mode 0, dead_time=0: toggle p_in 0->1 at cycle t -> dac_a=0x2000, dac_b=0x0000 at t+2; p_in back to 0 -> outputs return after 2 cycles.
3. Mode 0, dead_time=3: p_in 0->1 -> both channels =0x0000 for exactly 3 cycles, then dac_a=0x2000. A 1-cycle p_in glitch inside DEAD produces no extra phase.
4. Mode 1, half_period=5, dead_time=2 -> phase sequence 5 high, 2 dead, 5 low, 2 dead, repeating with period 14. half_period=0 -> 1-cycle halves.
5. Mode 2, burst_count=3, half_period=4, dead_time=1, single start -> exactly 3 high and 3 low halves. done pulses 1 cycle as busy falls. start during the burst is ignored. burst_count=0 -> done only, outputs unchanged.
6. Mode 2 burst aborted by enable=0 mid-HOLD -> IDLE next cycle, no done. Same with rst -> reset values (0/0) next cycle.
